// File: rtl/note_source_arbiter.sv
// Oscillator note-source arbiter: live keypad over sequencer playback, with a
// minimum sequencer hold before preemption and a silent gap on every note change.
//
// state | meaning
// IDLE  | no source owns the oscillator, evaluate both sources every edge
// LIVE  | keypad note latched on note_out
// SEQ   | sequencer note latched on note_out, hold counter running
// GAP   | forced silence between notes, gap counter running down
module note_source_arbiter #(
  parameter int GAP_CYCLES = 20,
  parameter int MIN_HOLD   = 500
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [3:0] live_note,
  input  logic [3:0] seq_note,
  input  logic       sequencer_on,
  output logic [3:0] note_out,
  output logic [1:0] src,
  output logic [7:0] preempt_cnt
);

  localparam int HW = (MIN_HOLD > 0) ? $clog2(MIN_HOLD + 1) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [HW-1:0] HOLD_MAX = HW'(MIN_HOLD);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

  localparam logic [1:0] SRC_NONE = 2'b00;
  localparam logic [1:0] SRC_LIVE = 2'b01;
  localparam logic [1:0] SRC_SEQ  = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LIVE = 2'd1,
    SEQ  = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t        state, state_nx;
  logic [3:0]    note_nx;
  logic [1:0]    src_nx;
  logic [HW-1:0] hold_cnt, hold_nx;
  logic [GW-1:0] gap_cnt, gap_nx;
  logic [7:0]    preempt_nx;
  logic          arb;
  logic          to_gap;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= IDLE;
      note_out    <= 4'd0;
      src         <= SRC_NONE;
      hold_cnt    <= '0;
      gap_cnt     <= '0;
      preempt_cnt <= 8'd0;
    end else begin
      state       <= state_nx;
      note_out    <= note_nx;
      src         <= src_nx;
      hold_cnt    <= hold_nx;
      gap_cnt     <= gap_nx;
      preempt_cnt <= preempt_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    note_nx    = note_out;
    src_nx     = src;
    hold_nx    = hold_cnt;
    gap_nx     = gap_cnt;
    preempt_nx = preempt_cnt;
    arb        = 1'b0;
    to_gap     = 1'b0;

    case (state)
      IDLE: arb = 1'b1;

      LIVE: begin
        if (live_note != note_out) to_gap = 1'b1;
      end

      SEQ: begin
        if (hold_cnt != HOLD_MAX) hold_nx = hold_cnt + HW'(1);
        if (!sequencer_on) begin
          to_gap = 1'b1;
        end else if (seq_note != note_out) begin
          to_gap = 1'b1;
        end else if (live_note != 4'd0 && hold_cnt == HOLD_MAX) begin
          to_gap = 1'b1;
          if (preempt_cnt != 8'hFF) preempt_nx = preempt_cnt + 8'd1;
        end
      end

      GAP: begin
        if (gap_cnt == '0) arb = 1'b1;
        else               gap_nx = gap_cnt - GW'(1);
      end

      default: begin
        state_nx = IDLE;
        note_nx  = 4'd0;
        src_nx   = SRC_NONE;
        hold_nx  = '0;
        gap_nx   = '0;
      end
    endcase

    if (to_gap) begin
      state_nx = GAP;
      note_nx  = 4'd0;
      src_nx   = SRC_NONE;
      gap_nx   = GAP_LOAD;
    end

    // Live always beats the sequencer when both request on the same edge.
    if (arb) begin
      if (live_note != 4'd0) begin
        state_nx = LIVE;
        note_nx  = live_note;
        src_nx   = SRC_LIVE;
      end else if (seq_note != 4'd0 && sequencer_on) begin
        state_nx = SEQ;
        note_nx  = seq_note;
        src_nx   = SRC_SEQ;
        hold_nx  = '0;
      end else begin
        state_nx = IDLE;
        note_nx  = 4'd0;
        src_nx   = SRC_NONE;
      end
    end
  end

endmodule

// File: doc/note_source_arbiter.md
Name: note_source_arbiter

Overview:
- Shares the single oscillator note input between live keypad notes and sequencer playback notes.
- Sits between the sequencer output (note_sustain, sequencer_on) and the oscillator.
- Enforces live-key priority, a minimum sequencer note hold before preemption, and a silent gap on every note change to avoid clicks.
- Counts sequencer notes cut short by live play.

Parameters:
- GAP_CYCLES, 20, clk cycles note_out is forced to 0 between any two notes; legal range is 1 or more (2 ms at 10 kHz).
- MIN_HOLD, 500, minimum clk cycles a sequencer note plays before live input may preempt it; legal range is 1 or more.

Ports:
- clk  input  1  system clock (10 kHz)
- n_rst  input  1  reset; one clock; reset is asynchronous and active-low
- live_note  input  4  live keypad note code; 0 = no key
- seq_note  input  4  sequencer note_sustain; 0 = silence
- sequencer_on  input  1  sequencer mode enable
- note_out  output  4  registered note to oscillator; 0 = silence
- src  output  2  owner of note_out: 00 none, 01 live, 10 sequencer
- preempt_cnt  output  8  saturating count of sequencer notes preempted by live input

Behaviour:
- Reset (async, n_rst=0):
  - state=IDLE, note_out=0, src=00, preempt_cnt=0, hold and gap counters 0.
  - Reset mid-note or mid-gap aborts immediately.
- All outputs are registered. Input sampled at edge k appears on outputs after edge k (1-cycle latency).
- Arbitration evaluation, applied in IDLE and at GAP exit:
  - live_note!=0 → LIVE, note_out=live_note, src=01.
  - else seq_note!=0 and sequencer_on=1 → SEQ, note_out=seq_note, src=10, hold_cnt=0.
  - else → IDLE, note_out=0, src=00.
  - Both sources nonzero in the same cycle: live wins.
- LIVE:
  - live_note equals latched note → stay.
  - live_note changes, to 0 or to a different code → GAP.
  - seq_note and sequencer_on are ignored; no count.
- SEQ:
  - hold_cnt increments each cycle, saturating at MIN_HOLD.
  - sequencer_on=0 → GAP, no count.
  - else seq_note differs from latched note (including 0) → GAP, no count.
  - else live_note!=0 and hold_cnt==MIN_HOLD → GAP and preempt_cnt+1, saturating at 255.
  - live_note!=0 with hold_cnt<MIN_HOLD → stay; the request stays pending and is re-checked every cycle.
  - Priority within SEQ is as listed: sequencer_on drop, then seq change, then preempt.
- GAP:
  - On entry: note_out=0, src=00, gap_cnt=GAP_CYCLES-1.
  - Decrements each cycle. Output is held silent for exactly GAP_CYCLES cycles.
  - On the edge where gap_cnt==0, perform arbitration evaluation on current inputs. Input changes during GAP are not latched.
- Unused or undefined state encodings recover to IDLE on the next edge.
- Counter widths:
  - hold_cnt: $clog2(MIN_HOLD+1) bits.
  - gap_cnt: $clog2(GAP_CYCLES) bits, minimum 1.
  - preempt_cnt never wraps.

Test Plan (bench uses GAP_CYCLES=4, MIN_HOLD=10):
- Reset, then live_note=5 sampled at edge 1 → note_out=5, src=01 after edge 1. live_note→7 at edge 6 → note_out=0 for 4 cycles, then 7 with src=01. preempt_cnt=0.
- sequencer_on=1, seq_note=3, live_note=0 → note_out=3, src=10. seq_note→9 → 4 cycles of 0, then 9.
- In SEQ, raise live_note=6 three cycles after SEQ entry → note_out stays 3 until hold_cnt=10, then 4 gap cycles, then 6/src=01. preempt_cnt=1.
- From IDLE, live_note=2 and seq_note=4 with sequencer_on=1 on the same edge → note_out=2, src=01.
- In SEQ, drop sequencer_on with live_note=0 → gap of 4, then note_out=0, src=00, IDLE. preempt_cnt unchanged. Then 300 forced preemptions → preempt_cnt saturates at 255.
- Assert n_rst=0 asynchronously mid-GAP and mid-SEQ → all outputs 0 immediately. After release with live_note=1 → note_out=1 one edge later.
